// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    // Memory-stage wait tracker: either running freely or waiting on data memory.
    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    // Control-field pattern loaded into a pipeline register to form a bubble.
    localparam logic [7:0] NOP_CTRL = 8'h00;

    // Default performance counter width.
    localparam int CNT_W_DEF = 16;

    // Minimum width of the consecutive memory-wait counter.
    localparam int WAIT_CTR_MIN_W = 8;

    // True when a producer writing register d (enabled by en) feeds an operand
    // of the ID instruction. Register 0 is hard-wired and never a dependency.
    function automatic logic reg_match(input logic [4:0] d,
                                       input logic       en,
                                       input logic [4:0] src1,
                                       input logic [4:0] src2,
                                       input logic       two_src);
        return en && (d != 5'd0) && ((d == src1) || (two_src && (d == src2)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes precedence over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    // Count qualifying cycles, sticking at all-ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the five-stage pipeline: data-hazard
// stalls, branch flushes, memory-wait freezes, wait timeout and perf counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       src1,
    input  logic [4:0]       src2,
    input  logic             two_src,
    input  logic [4:0]       exe_dest,
    input  logic [4:0]       mem_dest,
    input  logic             exe_wb_en,
    input  logic             mem_wb_en,
    input  logic             exe_mem_read,
    input  logic             forward_en,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             cnt_clear,
    output logic             hold_front,
    output logic             bubble_idexe,
    output logic             flush_ifid,
    output logic             freeze_all,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
);

    // The wait counter must reach TIMEOUT, which may be as large as the
    // performance counters allow, so it is at least CNT_W bits wide.
    localparam int WC_W = (CNT_W > WAIT_CTR_MIN_W) ? CNT_W : WAIT_CTR_MIN_W;
    localparam logic [WC_W:0]   TO_LIM = TIMEOUT[WC_W:0];
    localparam logic [WC_W-1:0] WC_ONE = {{(WC_W-1){1'b0}}, 1'b1};

    logic exe_hit;
    logic mem_hit;
    logic hazard;
    logic hazard_stall;

    mem_state_e      state, state_nxt;
    logic [WC_W-1:0] wait_ctr, wait_ctr_nxt;
    logic [WC_W:0]   frozen_run;
    logic            timeout_nxt;

    // Operand dependency on EXE/MEM producers. A load in EXE cannot be
    // forwarded yet; any producer stalls when forwarding is off.
    always_comb begin
        exe_hit = reg_match(exe_dest, exe_wb_en, src1, src2, two_src);
        mem_hit = reg_match(mem_dest, mem_wb_en, src1, src2, two_src);
        hazard  = (exe_hit && (exe_mem_read || !forward_en)) ||
                  (mem_hit && !forward_en);
    end

    // Output priority: reset, then memory freeze, then branch flush, then hazard stall.
    always_comb begin
        freeze_all   = 1'b0;
        flush_ifid   = 1'b0;
        bubble_idexe = 1'b0;
        hold_front   = 1'b0;
        hazard_stall = 1'b0;
        if (!reset) begin
            freeze_all = mem_req && !mem_ready;
            if (!freeze_all) begin
                flush_ifid   = branch_taken;
                bubble_idexe = branch_taken || hazard;
                hazard_stall = hazard && !branch_taken;
                hold_front   = hazard_stall;
            end
        end
    end

    // Number of consecutive frozen cycles including the current one. In RUN
    // the counter is zero, and every WAIT cycle so far has been frozen.
    assign frozen_run = {1'b0, wait_ctr} + {1'b0, WC_ONE};

    // Memory-wait tracker next state, wait counter and timeout detection.
    always_comb begin
        state_nxt    = state;
        wait_ctr_nxt = wait_ctr;
        timeout_nxt  = mem_timeout || (freeze_all && (frozen_run >= TO_LIM));
        case (state)
            RUN: begin
                if (freeze_all) begin
                    state_nxt    = WAIT;
                    wait_ctr_nxt = WC_ONE;
                end
            end
            WAIT: begin
                // Leaving WAIT covers both completion and an aborted access.
                if (!freeze_all) begin
                    state_nxt    = RUN;
                    wait_ctr_nxt = '0;
                end else if (wait_ctr != '1) begin
                    wait_ctr_nxt = wait_ctr + WC_ONE;
                end
            end
            default: begin
                state_nxt    = RUN;
                wait_ctr_nxt = '0;
            end
        endcase
    end

    // Wait tracker state registers; the timeout flag is sticky until reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            wait_ctr    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_ctr    <= wait_ctr_nxt;
            mem_timeout <= timeout_nxt;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (cnt_clear),
        .inc   (hazard_stall),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (cnt_clear),
        .inc   (flush_ifid),
        .count (flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_wait_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (cnt_clear),
        .inc   (freeze_all),
        .count (wait_cnt)
    );

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the five-stage pipeline. It watches operand usage in ID, destinations in EXE and MEM, the branch decision from EXE and the memory-stage handshake. From these it drives the hold, bubble and flush controls of the PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB pipeline registers. It also tracks memory-wait duration for a timeout flag and keeps saturating performance counters.

## Interface
Parameters:
- CNT_W, 16, width of each performance counter
- TIMEOUT, 255, maximum consecutive memory-wait cycles before `mem_timeout` sets (1..2^CNT_W-1)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- src1, src2  in  5 each  ID-stage source register numbers
- two_src  in  1  ID instruction reads src2 (R-type or store)
- exe_dest, mem_dest  in  5 each  destination registers in EXE and MEM
- exe_wb_en, mem_wb_en  in  1 each  write-back enables in EXE and MEM
- exe_mem_read  in  1  EXE instruction is a load
- forward_en  in  1  forwarding unit active
- branch_taken  in  1  EXE resolved a taken branch
- mem_req  in  1  MEM stage performs a load/store this cycle
- mem_ready  in  1  data memory completes the access this cycle
- cnt_clear  in  1  synchronous clear of all performance counters
- hold_front  out  1  hold PC and IF/ID
- bubble_idexe  out  1  load a NOP (all control fields 0) into ID/EXE
- flush_ifid  out  1  load a NOP into IF/ID
- freeze_all  out  1  hold every pipeline register and the PC
- mem_timeout  out  1  sticky memory-wait timeout error
- stall_cnt, flush_cnt, wait_cnt  out  CNT_W each  hazard-stall, flush and memory-wait cycle counts

## Operation
- Hazard term: `hazard = match(exe_dest, exe_wb_en) & (exe_mem_read | ~forward_en) | match(mem_dest, mem_wb_en) & ~forward_en`.
- `match(d, en)` = en & d≠0 & (d==src1 | two_src & d==src2).
- Register 0 never causes a hazard.
- `freeze_all = mem_req & ~mem_ready`. It is combinational and has the highest priority.
- While `freeze_all` = 1, `hold_front`, `bubble_idexe` and `flush_ifid` are forced to 0, because every stage is already held.
- `flush_ifid = bubble_idexe_from_branch = branch_taken & ~freeze_all`.
  - A taken branch overrides the hazard stall: the ID instruction is discarded, so `hold_front` = 0.
- Hazard stall, when there is no freeze and no branch: `hold_front = 1` and `bubble_idexe = 1`.
- `bubble_idexe = (branch_taken | hazard) & ~freeze_all`.
- Memory-wait FSM, states RUN and WAIT:
  - RUN -> WAIT when `freeze_all`.
  - WAIT -> RUN when `mem_ready`, or when `mem_req` drops (an aborted access).
  - A wait counter (8+ bits) increments each cycle in WAIT and clears on entry to RUN.
  - When `freeze_all` holds for TIMEOUT consecutive cycles, `mem_timeout` sets. It clears only on reset.
- Performance counters, each saturating at all-ones:
  - `stall_cnt` increments on cycles with a hazard-caused `hold_front`.
  - `flush_cnt` increments on cycles with `flush_ifid`.
  - `wait_cnt` increments on cycles with `freeze_all`.
  - `cnt_clear` zeroes all three counters. If a counter's increment coincides with `cnt_clear`, the clear wins and the counter reads 0.

## Timing
- `hold_front`, `bubble_idexe`, `flush_ifid` and `freeze_all` are combinational, zero latency, and valid before the same clock edge the pipeline registers sample.
- While `reset` = 1 all four are forced to 0.
- Reset values:
  - FSM = RUN
  - wait counter = 0
  - `mem_timeout` = 0
  - all performance counters = 0
- Load-use stalls last exactly one cycle with forwarding on. On the following cycle the load is in MEM, so there is no EXE match.
- Without forwarding, stalls last up to two cycles.
- A single-cycle access (`mem_req` and `mem_ready` in the same cycle) never enters WAIT and never freezes.
- With `freeze_all` asserted on cycles 0..N-1, `mem_timeout` rises after the edge ending cycle TIMEOUT-1. It does not rise if `mem_ready` arrives on or before cycle TIMEOUT-1.
- A branch that coincides with a freeze is re-presented after the unfreeze, because EXE was held. The flush then occurs exactly once.
- Reset asserted mid-WAIT: the FSM returns to RUN immediately and the counters clear asynchronously.

## Structure
- Package `pipe_ctrl_pkg`:
  - FSM state enum {RUN, WAIT}
  - NOP control constant
  - default CNT_W
- Sub-module `sat_counter #(W)`:
  - ports: clock, reset, clr, inc, count
  - instantiated three times for the performance counters
- Hazard compare logic and output muxing stay inline.

## Test plan
- Load-use: EXE = lw to r5 (exe_mem_read=1), ID src1=r5, forward_en=1 -> one cycle of `hold_front`=1 and `bubble_idexe`=1; `stall_cnt` 0->1.
- No forwarding: EXE writes r3, then MEM writes r3, ID src2=r3, two_src=1 -> two stall cycles. With two_src=0 -> no stall.
- Branch + hazard in the same cycle -> `flush_ifid`=1, `bubble_idexe`=1, `hold_front`=0; `flush_cnt`=1, `stall_cnt` unchanged.
- Memory wait: `mem_req`=1, `mem_ready` low for 4 cycles then high -> `freeze_all` high for 4 cycles, FSM RUN->WAIT->RUN, `wait_cnt`=4.
- Timeout: TIMEOUT=8, `mem_ready` held low for 10 cycles -> `mem_timeout` rises after the 8th frozen cycle and stays set after `mem_ready`.
- Saturation/clear: CNT_W=4, 20 stall cycles -> `stall_cnt`=15. Then `cnt_clear` concurrent with a stall -> 0. Async reset mid-WAIT -> all outputs 0 immediately.
